// File: rtl/wgt_fifo_bank_skewed.sv
// Lockstep bank of weight FIFOs with non-destructive replay bursts.
// Each lane can optionally start one cycle after the previous lane (diagonal skew).
module wgt_fifo_bank_skewed #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_FIFO   = 16,
  parameter int unsigned FIFO_DEPTH = 4608,
  parameter int unsigned SKEW_EN    = 1,
  localparam int unsigned AW = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned LW = $clog2(NUM_FIFO + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_clr,
  input  logic                           rd_clr,
  input  logic                           wr_en,
  input  logic [LW-1:0]                  wr_lanes,
  input  logic [DATA_WIDTH*NUM_FIFO-1:0] data_in,
  input  logic                           rd_start,
  input  logic [AW-1:0]                  rd_len,
  output logic [DATA_WIDTH*NUM_FIFO-1:0] data_out,
  output logic [NUM_FIFO-1:0]            out_valid,
  output logic                           rd_busy,
  output logic                           rd_done,
  output logic                           rd_err,
  output logic [AW-1:0]                  wr_count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned DW_ALL = DATA_WIDTH * NUM_FIFO;
  localparam int unsigned ADW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned SPAN   = SKEW_EN * (NUM_FIFO - 1);
  localparam int unsigned CW     = $clog2(SPAN + FIFO_DEPTH + 2);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [AW-1:0]       wr_count_q, wr_count_d;
  logic                full_q, full_d, empty_q, empty_d;
  logic [AW-1:0]       len_q, len_d;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic                rd_busy_q, rd_busy_d;
  logic                rd_done_q, rd_done_d;
  logic                rd_err_q, rd_err_d;
  logic [NUM_FIFO-1:0] out_valid_q, out_valid_d;
  logic [DW_ALL-1:0]   data_out_q, data_out_d;

  logic                clr, wr_fire, len_ok, start_ok;
  logic [CW-1:0]       done_cyc, last_cyc;
  logic [DW_ALL-1:0]   wdata;
  logic [NUM_FIFO-1:0] rd_en;

  logic [DATA_WIDTH-1:0] mem [NUM_FIFO][FIFO_DEPTH];

  // Shared control decode; cyc_q counts from 0 in the first RUN cycle
  always_comb begin
    clr      = rd_clr | wr_clr;
    wr_fire  = wr_en & ~full_q & ~wr_clr;
    len_ok   = (rd_len != '0) && (rd_len <= wr_count_q);
    start_ok = rd_start & ~clr & len_ok;
    done_cyc = CW'(SPAN) + CW'(len_q);
    last_cyc = done_cyc - CW'(1);
  end

  // Write side: occupancy and flags
  always_comb begin
    wr_count_d = wr_count_q;
    if (wr_clr) begin
      wr_count_d = '0;
    end else if (wr_fire) begin
      wr_count_d = wr_count_q + AW'(1);
    end
    full_d  = (wr_count_d == AW'(FIFO_DEPTH));
    empty_d = (wr_count_d == '0);
  end

  // Lanes at or above wr_lanes are stored as zero
  always_comb begin
    wdata = '0;
    for (int j = 0; j < NUM_FIFO; j++) begin
      if (LW'(j) < wr_lanes) begin
        wdata[j*DATA_WIDTH +: DATA_WIDTH] = data_in[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int j = 0; j < NUM_FIFO; j++) begin
        mem[j][ADW'(wr_count_q)] <= wdata[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (clr || (cyc_q == done_cyc)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and burst bookkeeping
  always_comb begin
    rd_err_d  = (state_q == IDLE) & rd_start & ~clr & ~len_ok;
    rd_done_d = (state_q == RUN) & ~clr & (cyc_q == last_cyc);
    rd_busy_d = (state_d == RUN);
    cyc_d     = ((state_q == RUN) && (state_d == RUN)) ? cyc_q + CW'(1) : '0;
    len_d     = ((state_q == IDLE) && start_ok) ? rd_len : len_q;
  end

  // Lane j reads address cyc_q - S*j while that offset is inside the burst
  always_comb begin
    rd_en       = '0;
    out_valid_d = '0;
    data_out_d  = '0;
    for (int j = 0; j < NUM_FIFO; j++) begin
      rd_en[j] = (state_q == RUN) && !clr && (cyc_q >= CW'(SKEW_EN * j)) &&
                 ((cyc_q - CW'(SKEW_EN * j)) < CW'(len_q));
      out_valid_d[j] = rd_en[j];
      if (rd_en[j]) begin
        data_out_d[j*DATA_WIDTH +: DATA_WIDTH] = mem[j][ADW'(cyc_q - CW'(SKEW_EN * j))];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count_q  <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      len_q       <= '0;
      cyc_q       <= '0;
      rd_busy_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      rd_err_q    <= 1'b0;
      out_valid_q <= '0;
      data_out_q  <= '0;
    end else begin
      wr_count_q  <= wr_count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      len_q       <= len_d;
      cyc_q       <= cyc_d;
      rd_busy_q   <= rd_busy_d;
      rd_done_q   <= rd_done_d;
      rd_err_q    <= rd_err_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign rd_busy   = rd_busy_q;
  assign rd_done   = rd_done_q;
  assign rd_err    = rd_err_q;
  assign wr_count  = wr_count_q;
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: tb/tb_wgt_fifo_bank_skewed.sv
// Bench for wgt_fifo_bank_skewed: a skewed and an unskewed instance share stimulus and
// are checked every cycle against a timing-formula model plus hand-computed values.
module tb_wgt_fifo_bank_skewed;

  localparam int unsigned DW    = 16;
  localparam int unsigned NF    = 16;
  localparam int unsigned DEPTH = 4608;
  localparam int unsigned AW    = $clog2(DEPTH + 1);
  localparam int unsigned LW    = $clog2(NF + 1);
  localparam int unsigned BW    = DW * NF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wr_clr, rd_clr, wr_en, rd_start;
  logic [LW-1:0] wr_lanes;
  logic [BW-1:0] data_in;
  logic [AW-1:0] rd_len;

  logic [BW-1:0] dout [2];
  logic [NF-1:0] oval [2];
  logic          busy [2];
  logic          done [2];
  logic          err  [2];
  logic [AW-1:0] wcnt [2];
  logic          full [2];
  logic          empty [2];

  wgt_fifo_bank_skewed #(.DATA_WIDTH(DW), .NUM_FIFO(NF), .FIFO_DEPTH(DEPTH), .SKEW_EN(1)) u_skew (
    .clk(clk), .rst(rst), .wr_clr(wr_clr), .rd_clr(rd_clr), .wr_en(wr_en),
    .wr_lanes(wr_lanes), .data_in(data_in), .rd_start(rd_start), .rd_len(rd_len),
    .data_out(dout[0]), .out_valid(oval[0]), .rd_busy(busy[0]), .rd_done(done[0]),
    .rd_err(err[0]), .wr_count(wcnt[0]), .full(full[0]), .empty(empty[0]));

  wgt_fifo_bank_skewed #(.DATA_WIDTH(DW), .NUM_FIFO(NF), .FIFO_DEPTH(DEPTH), .SKEW_EN(0)) u_flat (
    .clk(clk), .rst(rst), .wr_clr(wr_clr), .rd_clr(rd_clr), .wr_en(wr_en),
    .wr_lanes(wr_lanes), .data_in(data_in), .rd_start(rd_start), .rd_len(rd_len),
    .data_out(dout[1]), .out_valid(oval[1]), .rd_busy(busy[1]), .rd_done(done[1]),
    .rd_err(err[1]), .wr_count(wcnt[1]), .full(full[1]), .empty(empty[1]));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] lane(input int k, input int j);
    return dout[k][j*DW +: DW];
  endfunction

  function automatic logic [BW-1:0] w1(input int a);
    logic [BW-1:0] r;
    for (int j = 0; j < NF; j++) r[j*DW +: DW] = DW'(a * 16 + j);
    return r;
  endfunction

  function automatic logic [BW-1:0] w2(input int a);
    logic [BW-1:0] r;
    for (int j = 0; j < NF; j++) r[j*DW +: DW] = DW'(a * 7 + j * 13 + 1);
    return r;
  endfunction

  function automatic int skv(input int k);
    return (k == 0) ? 1 : 0;
  endfunction

  // Model state: burst start cycle/length per instance, stored words, write count
  bit            act [2];
  int            t0  [2];
  int            ln  [2];
  int            cur;
  int            cnt;
  logic [DW-1:0] mem_m [DEPTH][NF];
  logic [BW-1:0] e_dout [2];
  logic [NF-1:0] e_val  [2];
  logic          e_busy [2];
  logic          e_done [2];
  logic          e_err  [2];
  int            e_cnt;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      act[k] = 1'b0; t0[k] = 0; ln[k] = 0;
      e_dout[k] = '0; e_val[k] = '0; e_busy[k] = 1'b0; e_done[k] = 1'b0; e_err[k] = 1'b0;
    end
    cur = 0; cnt = 0; e_cnt = 0;
  endtask

  task automatic model_step();
    int  c, n, endc, lo;
    bit  clr_b, busy_c;
    bit  err_n [2];
    c = cur;
    clr_b = rd_clr | wr_clr;
    for (int k = 0; k < 2; k++) begin
      err_n[k] = 1'b0;
      endc = t0[k] + skv(k) * (NF - 1) + ln[k];
      busy_c = act[k] && (c >= t0[k]) && (c <= endc);
      if (clr_b) begin
        act[k] = 1'b0;
      end else if (!busy_c && rd_start) begin
        if ((int'(rd_len) >= 1) && (int'(rd_len) <= cnt)) begin
          act[k] = 1'b1; t0[k] = c + 1; ln[k] = int'(rd_len);
        end else begin
          err_n[k] = 1'b1;
        end
      end
    end
    if (wr_clr) begin
      cnt = 0;
    end else if (wr_en && (cnt < DEPTH)) begin
      for (int j = 0; j < NF; j++)
        mem_m[cnt][j] = (j < int'(wr_lanes)) ? data_in[j*DW +: DW] : '0;
      cnt++;
    end
    cur = c + 1;
    n = cur;
    for (int k = 0; k < 2; k++) begin
      endc = t0[k] + skv(k) * (NF - 1) + ln[k];
      e_busy[k] = act[k] && (n >= t0[k]) && (n <= endc);
      e_done[k] = act[k] && (n == endc);
      e_err[k]  = err_n[k];
      e_val[k]  = '0;
      e_dout[k] = '0;
      for (int j = 0; j < NF; j++) begin
        lo = t0[k] + skv(k) * j + 1;
        if (act[k] && (n >= lo) && (n < lo + ln[k])) begin
          e_val[k][j] = 1'b1;
          e_dout[k][j*DW +: DW] = mem_m[n - lo][j];
        end
      end
    end
    e_cnt = cnt;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("data_out[%0d]", k), dout[k], e_dout[k]);
          chk($sformatf("out_valid[%0d]", k), BW'(oval[k]), BW'(e_val[k]));
          chk($sformatf("rd_busy[%0d]", k), BW'(busy[k]), BW'(e_busy[k]));
          chk($sformatf("rd_done[%0d]", k), BW'(done[k]), BW'(e_done[k]));
          chk($sformatf("rd_err[%0d]", k), BW'(err[k]), BW'(e_err[k]));
          chk($sformatf("wr_count[%0d]", k), BW'(wcnt[k]), BW'(e_cnt));
          chk($sformatf("full[%0d]", k), BW'(full[k]), BW'(e_cnt == DEPTH));
          chk($sformatf("empty[%0d]", k), BW'(empty[k]), BW'(e_cnt == 0));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; wr_clr = 1'b0; rd_clr = 1'b0; wr_en = 1'b0; rd_start = 1'b0;
    wr_lanes = '0; data_in = '0; rd_len = '0;
    cyc(3);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_empty", BW'(empty[0]), BW'(1));
    chk("rst_count", BW'(wcnt[0]), BW'(0));
    chk("rst_valid", BW'(oval[0]), BW'(0));
    chk("rst_busy", BW'(busy[1]), BW'(0));

    // Full-width words a*16+j, skewed replay of 4
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_lanes = LW'(16); data_in = w1(a); cyc(1);
    end
    wr_en = 1'b0;
    chk("t1_count", BW'(wcnt[0]), BW'(4));
    rd_start = 1'b1; rd_len = AW'(4); cyc(1);
    // t0: ignored start while busy, plus a 3-lane write during RUN
    rd_start = 1'b1; rd_len = AW'(1);
    wr_en = 1'b1; wr_lanes = LW'(3); data_in = {NF{16'hAAAA}}; cyc(1);
    rd_start = 1'b0; wr_en = 1'b0;
    chk("t1_val_t1", BW'(oval[0]), BW'(16'h0001));
    chk("t1_lane0_t1", BW'(lane(0, 0)), BW'(0));
    chk("t1_flat_val_t1", BW'(oval[1]), BW'(16'hFFFF));
    chk("t1_no_err", BW'(err[0]), BW'(0));
    cyc(3);
    chk("t1_val_t4", BW'(oval[0]), BW'(16'h000F));
    chk("t1_lane0_t4", BW'(lane(0, 0)), BW'(48));
    chk("t1_lane3_t4", BW'(lane(0, 3)), BW'(3));
    chk("t1_flat_done_t4", BW'(done[1]), BW'(1));
    chk("t1_flat_lane15_t4", BW'(lane(1, 15)), BW'(63));
    cyc(15);
    chk("t1_done_t19", BW'(done[0]), BW'(1));
    chk("t1_val_t19", BW'(oval[0]), BW'(16'h8000));
    chk("t1_lane15_t19", BW'(lane(0, 15)), BW'(63));
    cyc(1);
    chk("t1_busy_t20", BW'(busy[0]), BW'(0));
    chk("t1_count_after", BW'(wcnt[0]), BW'(5));

    // Partial word at address 4
    rd_start = 1'b1; rd_len = AW'(5); cyc(1);
    rd_start = 1'b0;
    cyc(5);
    chk("t2_flat_val", BW'(oval[1]), BW'(16'hFFFF));
    chk("t2_flat_done", BW'(done[1]), BW'(1));
    chk("t2_flat_lane2", BW'(lane(1, 2)), BW'(16'hAAAA));
    chk("t2_flat_lane3", BW'(lane(1, 3)), BW'(0));
    chk("t2_val_t5", BW'(oval[0]), BW'(16'h001F));
    chk("t2_lane0_t5", BW'(lane(0, 0)), BW'(16'hAAAA));
    chk("t2_lane4_t5", BW'(lane(0, 4)), BW'(4));
    cyc(4);
    chk("t2_val_t9", BW'(oval[0]), BW'(16'h01F0));
    chk("t2_lane4_t9", BW'(lane(0, 4)), BW'(0));
    cyc(12);
    chk("t2_busy_end", BW'(busy[0]), BW'(0));

    // Rejected starts
    rd_start = 1'b1; rd_len = AW'(0); cyc(1);
    chk("t4_err_len0", BW'(err[0]), BW'(1));
    chk("t4_busy_len0", BW'(busy[0]), BW'(0));
    rd_len = AW'(6); cyc(1);
    rd_start = 1'b0;
    chk("t4_err_over", BW'(err[1]), BW'(1));
    chk("t4_busy_over", BW'(busy[1]), BW'(0));
    cyc(1);
    chk("t4_err_pulse", BW'(err[0]), BW'(0));

    // Back-to-back replays
    rd_start = 1'b1; rd_len = AW'(4); cyc(1);
    rd_start = 1'b0; cyc(20);
    rd_start = 1'b1; cyc(1);
    rd_start = 1'b0; cyc(4);
    chk("t5_flat_lane5", BW'(lane(1, 5)), BW'(53));
    chk("t5_lane3", BW'(lane(0, 3)), BW'(3));
    cyc(16);

    // rd_clr at t0+2
    rd_start = 1'b1; rd_len = AW'(4); cyc(1);
    rd_start = 1'b0; cyc(2);
    rd_clr = 1'b1; cyc(1);
    rd_clr = 1'b0;
    chk("t5_clr_val", BW'(oval[0]), BW'(0));
    chk("t5_clr_flat_val", BW'(oval[1]), BW'(0));
    chk("t5_clr_busy", BW'(busy[0]), BW'(0));
    chk("t5_clr_count", BW'(wcnt[0]), BW'(5));
    cyc(20);

    // Unskewed length-2 burst, then async reset mid-burst
    rd_start = 1'b1; rd_len = AW'(2); cyc(1);
    rd_start = 1'b0; cyc(1);
    chk("t6_flat_val_t1", BW'(oval[1]), BW'(16'hFFFF));
    cyc(1);
    chk("t6_flat_done_t2", BW'(done[1]), BW'(1));
    chk("t6_flat_lane0_t2", BW'(lane(1, 0)), BW'(16));
    cyc(1);
    chk("t6_flat_busy_t3", BW'(busy[1]), BW'(0));
    chk("t6_skew_busy_t3", BW'(busy[0]), BW'(1));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_val", BW'(oval[0]), BW'(0));
    chk("t6_rst_busy", BW'(busy[0]), BW'(0));
    chk("t6_rst_empty", BW'(empty[0]), BW'(1));
    chk("t6_rst_count", BW'(wcnt[1]), BW'(0));
    @(negedge clk);
    rst = 1'b0;
    cyc(1);

    // wr_clr aborts a running burst and wins over wr_en
    for (int a = 0; a < 2; a++) begin
      wr_en = 1'b1; wr_lanes = LW'(16); data_in = w1(a); cyc(1);
    end
    wr_en = 1'b0;
    rd_start = 1'b1; rd_len = AW'(2); cyc(1);
    rd_start = 1'b0; wr_clr = 1'b1; wr_en = 1'b1; cyc(1);
    wr_clr = 1'b0; wr_en = 1'b0;
    chk("wclr_val", BW'(oval[1]), BW'(0));
    chk("wclr_busy", BW'(busy[0]), BW'(0));
    chk("wclr_empty", BW'(empty[0]), BW'(1));
    chk("wclr_count", BW'(wcnt[0]), BW'(0));
    cyc(2);

    // Fill to depth with oversized wr_lanes, then full-length replay
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1'b1; wr_lanes = LW'(31); data_in = w2(a); cyc(1);
    end
    chk("t3_full", BW'(full[0]), BW'(1));
    chk("t3_count", BW'(wcnt[0]), BW'(DEPTH));
    data_in = w2(9999); cyc(2);
    wr_en = 1'b0;
    chk("t3_drop_count", BW'(wcnt[1]), BW'(DEPTH));
    chk("t3_drop_full", BW'(full[1]), BW'(1));
    rd_start = 1'b1; rd_len = AW'(DEPTH); cyc(1);
    rd_start = 1'b0;
    cyc(DEPTH);
    chk("t3_flat_done", BW'(done[1]), BW'(1));
    chk("t3_flat_last", BW'(lane(1, 7)), w2(DEPTH - 1) >> (7 * DW) & BW'(16'hFFFF));
    cyc(NF - 1);
    chk("t3_skew_done", BW'(done[0]), BW'(1));
    chk("t3_skew_last", BW'(lane(0, 15)), w2(DEPTH - 1) >> (15 * DW) & BW'(16'hFFFF));
    cyc(1);
    chk("t3_skew_idle", BW'(busy[0]), BW'(0));
    wr_clr = 1'b1; wr_en = 1'b1; cyc(1);
    wr_clr = 1'b0; wr_en = 1'b0;
    chk("t3_clr_empty", BW'(empty[0]), BW'(1));
    chk("t3_clr_full", BW'(full[0]), BW'(0));
    chk("t3_clr_count", BW'(wcnt[1]), BW'(0));
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
